delay_timer: RTL and testbench

Delay-instruction timer for the microfluidic flow-control processor. Sits beside the program counter and produces the `count_done` it consumes. When the decoded instruction at the current PC is a delay, the block loads the instruction's operand. It then counts that many timebase ticks while the PC holds, and issues a one-cycle `count_done` so the PC advances past the delay. Halts, resets and dropped delay requests abort the count cleanly.

---
 rtl/delay_timer.sv | 102 ++++++++++
 tb/tb_delay_timer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/delay_timer.sv
// Delay-instruction timer: loads a tick count when the PC holds a delay
// instruction, counts prescaled timebase ticks, then pulses count_done once.
module delay_timer #(
  parameter int PRESCALE = 100000,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             delay,
  input  logic             abort,
  input  logic [CNT_W-1:0] delay_val,
  output logic             count_done,
  output logic             busy,
  output logic [CNT_W-1:0] remaining,
  output logic [1:0]       dbg_state
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        pre_d = '0;
        rem_d = '0;
        // A halt always wins: abort blocks a load even with delay held high.
        if (delay && !abort) begin
          if (delay_val != '0) begin
            rem_d   = delay_val;
            state_d = S_COUNT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_COUNT: begin
        if (abort || !delay) begin
          state_d = S_IDLE;
          rem_d   = '0;
          pre_d   = '0;
        end else if (pre_q == PRE_MAX) begin
          pre_d = '0;
          if (rem_q != '0) rem_d = rem_q - CNT_W'(1);
          if (rem_q <= CNT_W'(1)) state_d = S_DONE;
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      S_DONE: begin
        // The pulse is never cut short, even by abort.
        state_d = S_IDLE;
        rem_d   = '0;
        pre_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        rem_d   = '0;
        pre_d   = '0;
      end
    endcase
  end

  assign done_d = (state_d == S_DONE);
  assign busy_d = (state_d != S_IDLE);

  assign count_done = done_q;
  assign busy       = busy_q;
  assign remaining  = rem_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_delay_timer.sv
// Bench for delay_timer: three instances (PRESCALE 1, 2, 4) share stimulus and
// are checked every cycle against an elapsed-time model, plus directed scenarios.
module tb_delay_timer;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             delay;
  logic             abort;
  logic [CNT_W-1:0] delay_val;

  logic             cd  [3];
  logic             bz  [3];
  logic [CNT_W-1:0] rem [3];
  logic [1:0]       st  [3];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Handshake: delay is a level request held by the PC; count_done is a
  // one-cycle response and needs no acknowledge.

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int P = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    delay_timer #(.PRESCALE(P), .CNT_W(CNT_W)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .delay      (delay),
      .abort      (abort),
      .delay_val  (delay_val),
      .count_done (cd[g]),
      .busy       (bz[g]),
      .remaining  (rem[g]),
      .dbg_state  (st[g])
    );
  end

  function automatic int ps(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  // Model: 0 idle, 1 counting (t cycles elapsed of n*P), 2 done pulse.
  int m_mode [3];
  int m_n    [3];
  int m_t    [3];
  bit model_valid = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_mode[k] = 0; m_n[k] = 0; m_t[k] = 0;
      end else if (m_mode[k] == 0) begin
        if (delay && !abort) begin
          if (delay_val == 0) m_mode[k] = 2;
          else begin
            m_mode[k] = 1; m_n[k] = int'(delay_val); m_t[k] = 0;
          end
        end
      end else if (m_mode[k] == 1) begin
        if (abort || !delay) m_mode[k] = 0;
        else begin
          m_t[k] = m_t[k] + 1;
          if (m_t[k] == m_n[k] * ps(k)) m_mode[k] = 2;
        end
      end else begin
        m_mode[k] = 0;
      end
    end
    if (rst) model_valid = 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  int pulse_q0[$];
  int pulse_q1[$];
  int pulse_q2[$];

  always @(negedge clk) begin
    if (model_valid) begin
      for (int k = 0; k < 3; k++) begin
        int exp_rem;
        exp_rem = (m_mode[k] == 1) ? (m_n[k] - m_t[k] / ps(k)) : 0;
        check($sformatf("model_count_done%0d", k), int'(cd[k]), (m_mode[k] == 2) ? 1 : 0);
        check($sformatf("model_busy%0d", k), int'(bz[k]), (m_mode[k] != 0) ? 1 : 0);
        check($sformatf("model_remaining%0d", k), int'(rem[k]), exp_rem);
      end
    end
    if (cd[0] === 1'b1) pulse_q0.push_back(cyc);
    if (cd[1] === 1'b1) pulse_q1.push_back(cyc);
    if (cd[2] === 1'b1) pulse_q2.push_back(cyc);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic reset_dut();
    rst = 1'b1; delay = 1'b0; abort = 1'b0; delay_val = '0;
    step(2);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_count_done%0d", k), int'(cd[k]), 0);
      check($sformatf("rst_busy%0d", k), int'(bz[k]), 0);
      check($sformatf("rst_remaining%0d", k), int'(rem[k]), 0);
    end
    rst = 1'b0;
    pulse_q0.delete(); pulse_q1.delete(); pulse_q2.delete();
  endtask

  int e0;
  int e1;

  initial begin
    rst = 1'b1; delay = 1'b0; abort = 1'b0; delay_val = '0;

    // Nominal: P=4, 3 ticks; pulse in the cycle after E0+12.
    reset_dut();
    delay = 1'b1; delay_val = 8'd3;
    step(1); e0 = cyc;
    check("nom_rem_e0", int'(rem[2]), 3);
    step(4); check("nom_rem_e4", int'(rem[2]), 2);
    step(4); check("nom_rem_e8", int'(rem[2]), 1);
    step(5);
    check("nom_pulse_cnt", pulse_q2.size(), 1);
    if (pulse_q2.size() == 1) check("nom_pulse_time", pulse_q2[0], e0 + 12);
    check("nom_busy_after", int'(bz[2]), 0);
    delay = 1'b0;
    step(2);

    // Zero delay: pulse straight after the load edge.
    reset_dut();
    delay = 1'b1; delay_val = 8'd0;
    step(1);
    check("zero_count_done", int'(cd[2]), 1);
    check("zero_remaining", int'(rem[2]), 0);
    check("zero_busy", int'(bz[2]), 1);
    delay = 1'b0;
    step(2);

    // Abort at E0+6, held: no reload while abort is high.
    reset_dut();
    delay = 1'b1; delay_val = 8'd5;
    step(1);
    step(5); abort = 1'b1;
    step(1);
    check("abort_busy", int'(bz[2]), 0);
    check("abort_remaining", int'(rem[2]), 0);
    check("abort_state", int'(st[2]), 0);
    step(3);
    check("abort_no_reload", int'(bz[2]), 0);
    abort = 1'b0; delay = 1'b0;
    step(1);
    check("abort_no_pulse", pulse_q2.size(), 0);

    // Reset at E0+7, then a clean reload.
    reset_dut();
    delay = 1'b1; delay_val = 8'd3;
    step(1);
    step(6); rst = 1'b1;
    step(1);
    check("midrst_count_done", int'(cd[2]), 0);
    check("midrst_busy", int'(bz[2]), 0);
    check("midrst_remaining", int'(rem[2]), 0);
    check("midrst_state", int'(st[2]), 0);
    rst = 1'b0;
    step(1); e1 = cyc;
    check("midrst_reload_rem", int'(rem[2]), 3);
    step(13);
    check("midrst_pulse_cnt", pulse_q2.size(), 1);
    if (pulse_q2.size() == 1) check("midrst_pulse_time", pulse_q2[0], e1 + 12);
    delay = 1'b0;
    step(2);

    // Back-to-back with P=1: values 2 then 1.
    reset_dut();
    delay = 1'b1; delay_val = 8'd2;
    step(1); e0 = cyc;
    delay_val = 8'd1;
    step(6);
    delay = 1'b0;
    step(4);
    check("b2b_pulse_cnt", pulse_q0.size(), 2);
    if (pulse_q0.size() == 2) begin
      check("b2b_pulse0_time", pulse_q0[0], e0 + 2);
      check("b2b_pulse1_time", pulse_q0[1], e0 + 5);
    end

    // Dropped request: delay falls at E0+3 with P=2, value 4.
    reset_dut();
    delay = 1'b1; delay_val = 8'd4;
    step(1);
    step(2); delay = 1'b0;
    step(1);
    check("drop_busy", int'(bz[1]), 0);
    check("drop_remaining", int'(rem[1]), 0);
    step(10);
    check("drop_no_pulse", pulse_q1.size(), 0);

    // Randomised traffic, checked by the per-cycle model compare.
    reset_dut();
    repeat (4000) begin
      step(1);
      rst   = ($urandom_range(0, 299) == 0);
      abort = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 39) == 0) delay = ($urandom_range(0, 3) != 0);
      delay_val = CNT_W'($urandom_range(0, 9));
    end
    rst = 1'b0; delay = 1'b0; abort = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
